// File: rtl/pc_unit.sv
// Program-counter stage: reset vector, prioritised redirect (exc > stall > ret > branch/jump > seq),
// EPC capture and a circular return-address stack. One-cycle redirect latency; i_pcWrite=0 holds the PC except for exceptions.
module pc_unit #(
    parameter int              PC_W      = 32,
    parameter logic [PC_W-1:0] RESET_VEC = '0,
    parameter logic [PC_W-1:0] EXC_VEC   = PC_W'(32'h0000_0040),
    parameter int              PC_INC    = 1,
    parameter int              RAS_DEPTH = 4
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_pcWrite,
    input  logic                         i_exc,
    input  logic [PC_W-1:0]              i_exc_pc,
    input  logic                         i_branch,
    input  logic                         i_jump,
    input  logic [PC_W-1:0]              i_target,
    input  logic                         i_call,
    input  logic                         i_ret,
    output logic [PC_W-1:0]              o_pc,
    output logic [PC_W-1:0]              o_pc_seq,
    output logic [PC_W-1:0]              o_epc,
    output logic [$clog2(RAS_DEPTH):0]   o_ras_count,
    output logic                         o_ras_empty,
    output logic                         o_ras_full,
    output logic                         o_ras_uflow
);
    localparam int              PTR_W = $clog2(RAS_DEPTH);
    localparam int              CNT_W = PTR_W + 1;
    localparam logic [PC_W-1:0] INC   = PC_W'(PC_INC);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RAS_DEPTH);

    logic [PC_W-1:0]  pc, epc, pc_nxt, epc_nxt;
    logic [PTR_W-1:0] ptr, ptr_nxt, wr_idx;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             uflow, uflow_nxt, wr_en, push;
    logic [PC_W-1:0]  ras [RAS_DEPTH];

    assign o_pc_seq = pc + INC;
    assign push     = i_call & i_jump;

    always_comb begin
        pc_nxt    = pc;
        epc_nxt   = epc;
        ptr_nxt   = ptr;
        cnt_nxt   = cnt;
        uflow_nxt = 1'b0;
        wr_en     = 1'b0;
        wr_idx    = ptr + PTR_W'(1);
        if (i_exc) begin
            pc_nxt  = EXC_VEC;
            epc_nxt = i_exc_pc;
        end else if (i_pcWrite) begin
            if (i_ret) begin
                if (cnt != '0) begin
                    pc_nxt = ras[ptr];
                    if (push) begin
                        // jalr-like: pop and push cancel, the new link overwrites the top slot
                        wr_en  = 1'b1;
                        wr_idx = ptr;
                    end else begin
                        ptr_nxt = ptr - PTR_W'(1);
                        cnt_nxt = cnt - CNT_W'(1);
                    end
                end else begin
                    pc_nxt    = i_target;
                    uflow_nxt = 1'b1;
                    if (push) begin
                        wr_en   = 1'b1;
                        ptr_nxt = ptr + PTR_W'(1);
                        cnt_nxt = CNT_W'(1);
                    end
                end
            end else if (i_branch | i_jump) begin
                pc_nxt = i_target;
                if (push) begin
                    // when full the pointer wraps onto the oldest entry
                    wr_en   = 1'b1;
                    ptr_nxt = ptr + PTR_W'(1);
                    cnt_nxt = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
                end
            end else begin
                pc_nxt = o_pc_seq;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pc    <= RESET_VEC;
            epc   <= '0;
            ptr   <= '0;
            cnt   <= '0;
            uflow <= 1'b0;
        end else begin
            pc    <= pc_nxt;
            epc   <= epc_nxt;
            ptr   <= ptr_nxt;
            cnt   <= cnt_nxt;
            uflow <= uflow_nxt;
        end
    end

    always_ff @(posedge i_clk) begin
        if (wr_en && !i_rst) begin
            ras[wr_idx] <= o_pc_seq;
        end
    end

    assign o_pc        = pc;
    assign o_epc       = epc;
    assign o_ras_count = cnt;
    assign o_ras_empty = (cnt == '0);
    assign o_ras_full  = (cnt == CNT_MAX);
    assign o_ras_uflow = uflow;
endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: directed scenarios plus randomized traffic against a queue-based reference model.
module tb_pc_unit;
    logic        clk = 1'b0;
    logic        rst, pcw, exc, branch, jump, call, ret;
    logic [31:0] exc_pc, target;
    logic [31:0] pc, pc_seq, epc, pc4, pc_seq4, epc4;
    logic [2:0]  cnt, cnt4;
    logic        emp, full, uf, emp4, full4, uf4;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [31:0] m_pc, m_epc;
    logic        m_uf;
    logic [31:0] m_ras[$];

    always #5 clk = ~clk;

    pc_unit #(.PC_W(32), .RESET_VEC(32'h100), .EXC_VEC(32'h40), .PC_INC(1), .RAS_DEPTH(4)) dut (
        .i_clk(clk), .i_rst(rst), .i_pcWrite(pcw), .i_exc(exc), .i_exc_pc(exc_pc),
        .i_branch(branch), .i_jump(jump), .i_target(target), .i_call(call), .i_ret(ret),
        .o_pc(pc), .o_pc_seq(pc_seq), .o_epc(epc), .o_ras_count(cnt),
        .o_ras_empty(emp), .o_ras_full(full), .o_ras_uflow(uf));

    pc_unit #(.PC_W(32), .RESET_VEC(32'h0), .EXC_VEC(32'h40), .PC_INC(4), .RAS_DEPTH(4)) dut4 (
        .i_clk(clk), .i_rst(rst), .i_pcWrite(pcw), .i_exc(exc), .i_exc_pc(exc_pc),
        .i_branch(branch), .i_jump(jump), .i_target(target), .i_call(call), .i_ret(ret),
        .o_pc(pc4), .o_pc_seq(pc_seq4), .o_epc(epc4), .o_ras_count(cnt4),
        .o_ras_empty(emp4), .o_ras_full(full4), .o_ras_uflow(uf4));

    // Reference model for the PC_INC=1 instance: the RAS is a plain stack that drops its oldest entry past 4.
    task automatic model_step();
        logic [31:0] nxt;
        if (rst) begin
            m_pc = 32'h100; m_epc = 0; m_uf = 0; m_ras.delete();
            return;
        end
        m_uf = 0;
        nxt  = m_pc;
        if (exc) begin
            nxt = 32'h40; m_epc = exc_pc;
        end else if (pcw) begin
            if (ret) begin
                if (m_ras.size() > 0) nxt = m_ras.pop_back();
                else begin nxt = target; m_uf = 1; end
            end else if (branch || jump) nxt = target;
            else nxt = m_pc + 1;
            if ((ret || branch || jump) && call && jump) begin
                m_ras.push_back(m_pc + 1);
                if (m_ras.size() > 4) void'(m_ras.pop_front());
            end
        end
        m_pc = nxt;
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 0; pcw = 1; exc = 0; exc_pc = 0; branch = 0; jump = 0; call = 0; ret = 0; target = 0;
    endtask

    task automatic go_to(input logic [31:0] a);
        idle(); branch = 1; target = a; cycle(); idle();
    endtask

    task automatic jal(input logic [31:0] a);
        idle(); jump = 1; call = 1; target = a; cycle(); idle();
    endtask

    task automatic test_reset();
        idle(); rst = 1; cycle(); cycle();
        n_cmp++; if (pc !== 32'h100) begin n_fail++; $display("FAIL reset_pc: got %h want 00000100", pc); end
        n_cmp++; if (epc !== 32'h0) begin n_fail++; $display("FAIL reset_epc: got %h want 0", epc); end
        n_cmp++; if (emp !== 1'b1 || cnt !== 3'd0) begin n_fail++; $display("FAIL reset_ras: empty %b count %0d want 1/0", emp, cnt); end
        rst = 0; cycle();
        n_cmp++; if (pc !== 32'h101) begin n_fail++; $display("FAIL seq1: got %h want 00000101", pc); end
        cycle();
        n_cmp++; if (pc !== 32'h102) begin n_fail++; $display("FAIL seq2: got %h want 00000102", pc); end
        n_cmp++; if (pc_seq !== 32'h103) begin n_fail++; $display("FAIL pc_seq: got %h want 00000103", pc_seq); end
    endtask

    task automatic test_stall_exc();
        go_to(32'h105);
        pcw = 0; branch = 1; target = 32'h200; cycle(); cycle();
        n_cmp++; if (pc !== 32'h105) begin n_fail++; $display("FAIL stall_hold: got %h want 00000105", pc); end
        exc = 1; exc_pc = 32'h104; cycle(); idle();
        n_cmp++; if (pc !== 32'h40) begin n_fail++; $display("FAIL exc_pc: got %h want 00000040", pc); end
        n_cmp++; if (epc !== 32'h104) begin n_fail++; $display("FAIL exc_epc: got %h want 00000104", epc); end
    endtask

    task automatic test_call_ret();
        go_to(32'h10);
        jal(32'h80);
        n_cmp++; if (pc !== 32'h80 || cnt !== 3'd1) begin n_fail++; $display("FAIL jal: pc %h count %0d want 00000080/1", pc, cnt); end
        go_to(32'h85);
        ret = 1; target = 32'h999; cycle(); idle();
        n_cmp++; if (pc !== 32'h11 || cnt !== 3'd0) begin n_fail++; $display("FAIL ret: pc %h count %0d want 00000011/0", pc, cnt); end
    endtask

    task automatic test_overflow();
        logic [31:0] exp_ret[4];
        exp_ret = '{32'h51, 32'h41, 32'h31, 32'h21};
        for (int i = 1; i <= 5; i++) begin
            go_to(32'h10 * i);
            jal(32'h1000);
        end
        n_cmp++; if (full !== 1'b1 || cnt !== 3'd4) begin n_fail++; $display("FAIL ovf_full: full %b count %0d want 1/4", full, cnt); end
        for (int i = 0; i < 4; i++) begin
            ret = 1; target = 32'hdead; cycle(); idle();
            n_cmp++; if (pc !== exp_ret[i]) begin n_fail++; $display("FAIL ovf_ret%0d: got %h want %h", i, pc, exp_ret[i]); end
        end
        ret = 1; target = 32'h300; cycle(); idle();
        n_cmp++; if (pc !== 32'h300 || uf !== 1'b1) begin n_fail++; $display("FAIL uflow: pc %h uflow %b want 00000300/1", pc, uf); end
        cycle();
        n_cmp++; if (uf !== 1'b0 || cnt !== 3'd0) begin n_fail++; $display("FAIL uflow_clear: uflow %b count %0d want 0/0", uf, cnt); end
    endtask

    task automatic test_jalr_empty();
        ret = 1; jump = 1; call = 1; target = 32'h700; cycle(); idle();
        n_cmp++; if (pc !== 32'h700 || uf !== 1'b1 || cnt !== 3'd1) begin n_fail++; $display("FAIL jalr_empty: pc %h uflow %b count %0d want 00000700/1/1", pc, uf, cnt); end
    endtask

    task automatic test_priority_wrap();
        exc = 1; exc_pc = 32'h77; branch = 1; ret = 1; target = 32'h500; cycle(); idle();
        n_cmp++; if (pc !== 32'h40 || cnt !== 3'd1) begin n_fail++; $display("FAIL priority: pc %h count %0d want 00000040/1", pc, cnt); end
        go_to(32'hFFFF_FFFC);
        n_cmp++; if (pc4 !== 32'hFFFF_FFFC || pc_seq4 !== 32'h0) begin n_fail++; $display("FAIL wrap_pre: pc %h seq %h want fffffffc/0", pc4, pc_seq4); end
        cycle();
        n_cmp++; if (pc4 !== 32'h0) begin n_fail++; $display("FAIL wrap: got %h want 0", pc4); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            idle();
            rst    = ($urandom_range(99) < 2);
            exc    = ($urandom_range(99) < 5);
            pcw    = ($urandom_range(99) < 85);
            ret    = ($urandom_range(99) < 20);
            branch = ($urandom_range(99) < 15);
            jump   = ($urandom_range(99) < 30);
            call   = ($urandom_range(99) < 50);
            exc_pc = $urandom;
            target = $urandom;
            cycle();
            n_cmp++; if (pc !== m_pc) begin n_fail++; $display("FAIL rnd_pc[%0d]: got %h want %h", i, pc, m_pc); end
            n_cmp++; if (pc_seq !== m_pc + 32'd1) begin n_fail++; $display("FAIL rnd_seq[%0d]: got %h want %h", i, pc_seq, m_pc + 32'd1); end
            n_cmp++; if (epc !== m_epc) begin n_fail++; $display("FAIL rnd_epc[%0d]: got %h want %h", i, epc, m_epc); end
            n_cmp++; if (int'(cnt) != m_ras.size()) begin n_fail++; $display("FAIL rnd_count[%0d]: got %0d want %0d", i, cnt, m_ras.size()); end
            n_cmp++; if (emp !== (m_ras.size() == 0) || full !== (m_ras.size() == 4)) begin n_fail++; $display("FAIL rnd_flags[%0d]: empty %b full %b size %0d", i, emp, full, m_ras.size()); end
            n_cmp++; if (uf !== m_uf) begin n_fail++; $display("FAIL rnd_uflow[%0d]: got %b want %b", i, uf, m_uf); end
        end
        idle();
    endtask

    initial begin
        idle();
        m_pc = 0; m_epc = 0; m_uf = 0;
        test_reset();
        test_stall_exc();
        test_call_ret();
        test_overflow();
        test_jalr_empty();
        test_priority_wrap();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
